// File: rtl/dct_pkg.sv
// Shared constants and helpers for the DCT coefficient link: size codes and row length mapping.
`default_nettype none

package dct_pkg;

  localparam int MAX_N = 32;
  localparam int IDX_W = 5;

  typedef enum logic [2:0] {
    SIZE_4  = 3'd0,
    SIZE_8  = 3'd1,
    SIZE_16 = 3'd2,
    SIZE_32 = 3'd3
  } size_e;

  // Codes above SIZE_32 saturate to a 32-point row.
  function automatic logic [IDX_W:0] size_to_n(input logic [2:0] size);
    logic [1:0] code;
    code = (size > SIZE_32) ? 2'd3 : size[1:0];
    return (IDX_W+1)'(4) << code;
  endfunction

  function automatic logic [IDX_W-1:0] size_to_last_idx(input logic [2:0] size);
    logic [IDX_W:0] n_m1;
    n_m1 = size_to_n(size) - (IDX_W+1)'(1);
    return n_m1[IDX_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dct_deser_fifo2.sv
// Two-entry FIFO of {data, idx, last}; slot 0 is always the head so outputs come straight from flops.
`default_nettype none

module dct_deser_fifo2
  import dct_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             push_last,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [IDX_W-1:0] head_idx,
  output logic             head_last,
  output logic             full,
  output logic             empty
);

  localparam int ENTRY_W = WIDTH + IDX_W + 1;

  logic [ENTRY_W-1:0] slot0;
  logic [ENTRY_W-1:0] slot1;
  logic [1:0]         count;
  logic               pop_ok;
  logic               push_ok;
  logic [1:0]         count_after_pop;
  logic [ENTRY_W-1:0] push_entry;

  assign empty           = (count == 2'd0);
  assign full            = (count == 2'd2);
  assign pop_ok          = pop && !empty;
  assign push_ok         = push && (!full || pop_ok);
  assign count_after_pop = count - {1'b0, pop_ok};
  assign push_entry      = {push_data, push_idx, push_last};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      if (pop_ok) begin
        slot0 <= slot1;
      end
      // A push into an empty-after-pop FIFO lands in the head slot, overriding the shift.
      if (push_ok) begin
        if (count_after_pop == 2'd0) begin
          slot0 <= push_entry;
        end else begin
          slot1 <= push_entry;
        end
      end
      count <= count_after_pop + {1'b0, push_ok};
    end
  end

  assign head_data = slot0[ENTRY_W-1 -: WIDTH];
  assign head_idx  = slot0[IDX_W:1];
  assign head_last = slot0[0];

endmodule

`default_nettype wire

// File: rtl/dct_sdat_deser.sv
// Serial-to-parallel receiver for the DCT coefficient link with row indexing and fault flags.
// Define DCT_DESER_PARITY_EN to expect an even-parity bit after each word.
`default_nettype none

module dct_sdat_deser
  import dct_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iSDAT,
  input  logic             iSVAL,
  input  logic [2:0]       iSize,
  input  logic             iReady,
  output logic [WIDTH-1:0] oData,
  output logic             oValid,
  output logic [IDX_W-1:0] oIdx,
  output logic             oLast,
  output logic             oErr,
  output logic             oOvf,
  output logic             oBusy
);

`ifdef DCT_DESER_PARITY_EN
  localparam int PERIOD = WIDTH + 1;
`else
  localparam int PERIOD = WIDTH;
`endif
  localparam int CNT_W = 6;

  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [IDX_W-1:0] row_idx;
  logic [IDX_W-1:0] last_idx;
  logic             stg_valid;
  logic [WIDTH-1:0] stg_data;
  logic [IDX_W-1:0] stg_idx;
  logic             stg_last;
  logic             err_q;
  logic             ovf_q;

  logic             row_start;
  logic             word_end;
  logic             at_last;
  logic [WIDTH-1:0] word_data;
  logic             par_ok;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             overflow;

  assign row_start = (bit_cnt == '0) && (row_idx == '0);
  assign word_end  = iSVAL && (bit_cnt == CNT_W'(PERIOD - 1));
  assign at_last   = (row_idx == last_idx);

`ifdef DCT_DESER_PARITY_EN
  assign word_data = sreg;
  assign par_ok    = ((^sreg) == iSDAT);
`else
  assign word_data = {sreg[WIDTH-2:0], iSDAT};
  assign par_ok    = 1'b1;
`endif

  assign oValid   = !fifo_empty;
  assign fifo_pop = oValid && iReady;
  // Completions are at least two cycles apart, so the staging register is always free here.
  assign overflow = word_end && par_ok && fifo_full && !fifo_pop;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      row_idx   <= '0;
      last_idx  <= '0;
      stg_valid <= 1'b0;
      stg_data  <= '0;
      stg_idx   <= '0;
      stg_last  <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      stg_valid <= 1'b0;
      if (iSVAL) begin
        if (row_start) begin
          last_idx <= size_to_last_idx(iSize);
        end
        if (bit_cnt < CNT_W'(WIDTH)) begin
          sreg <= {sreg[WIDTH-2:0], iSDAT};
        end
        if (word_end) begin
          bit_cnt <= '0;
          row_idx <= at_last ? '0 : row_idx + 1'b1;
          if (!par_ok) begin
            err_q <= 1'b1;
          end else if (overflow) begin
            ovf_q <= 1'b1;
          end else begin
            stg_valid <= 1'b1;
            stg_data  <= word_data;
            stg_idx   <= row_idx;
            stg_last  <= at_last;
          end
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (bit_cnt != '0) begin
        bit_cnt <= '0;
        row_idx <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  dct_deser_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clk       (iClk),
    .rst       (iRst),
    .push      (stg_valid),
    .push_data (stg_data),
    .push_idx  (stg_idx),
    .push_last (stg_last),
    .pop       (fifo_pop),
    .head_data (oData),
    .head_idx  (oIdx),
    .head_last (oLast),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign oErr  = err_q;
  assign oOvf  = ovf_q;
  assign oBusy = (bit_cnt != '0) || (row_idx != '0);

endmodule

`default_nettype wire
